// File: rtl/bsg_activation_pkg.sv
// Shared types and constants for the activation-engine arbiter slice.
// Used by bsg_activation_arbiter (optional BSG_ACTIVATION_ARBITER_PERF_EN counters) and bsg_activation_rr_pick.
package bsg_activation_pkg;

    typedef enum logic [1:0] {
        e_IDLE  = 2'd0,
        e_ISSUE = 2'd1,
        e_BUSY  = 2'd2
    } bsg_activation_arb_state_e;

    localparam int unsigned bsg_act_precision_lp = 16;
    localparam logic [31:0] bsg_act_one_lp       = 32'd1 << bsg_act_precision_lp;
    localparam int unsigned bsg_act_cnt_width_lp = 32;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [bsg_act_cnt_width_lp-1:0] bsg_act_sat_inc(
        input logic [bsg_act_cnt_width_lp-1:0] v
    );
        return (v == {bsg_act_cnt_width_lp{1'b1}}) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/bsg_activation_rr_pick.sv
// Combinational round-robin pick: first valid requester searching upward from last_i+1, wrapping.
module bsg_activation_rr_pick
    import bsg_activation_pkg::*;
#(
    parameter int num_req_p  = 4,
    parameter int id_width_p = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]  v_i,
    input  logic [id_width_p-1:0] last_i,
    output logic [num_req_p-1:0]  grant_o,
    output logic [id_width_p-1:0] winner_o,
    output logic                  any_v_o
);

    logic                  hi_any_s;
    logic [id_width_p-1:0] hi_idx_s;
    logic                  lo_any_s;
    logic [id_width_p-1:0] lo_idx_s;

    // Descending scan so the lowest qualifying index wins; "hi" only sees indices above last_i.
    always_comb begin
        hi_any_s = 1'b0;
        hi_idx_s = '0;
        lo_any_s = 1'b0;
        lo_idx_s = '0;
        for (int j = num_req_p - 1; j >= 0; j--) begin
            lo_any_s = lo_any_s | v_i[j];
            lo_idx_s = v_i[j] ? id_width_p'(j) : lo_idx_s;
            hi_any_s = hi_any_s | (v_i[j] & (32'(j) > 32'(last_i)));
            hi_idx_s = (v_i[j] && (32'(j) > 32'(last_i))) ? id_width_p'(j) : hi_idx_s;
        end
    end

    // Prefer requesters above the previous winner, otherwise wrap to the lowest valid one.
    always_comb begin
        any_v_o  = lo_any_s;
        winner_o = hi_any_s ? hi_idx_s : lo_idx_s;
        grant_o  = '0;
        grant_o[winner_o] = lo_any_s;
    end

endmodule

// File: rtl/bsg_activation_arbiter.sv
// Shares one bsg_activation engine among num_req_p requesters, one transaction at a time.
// Define BSG_ACTIVATION_ARBITER_PERF_EN to add grant_count_o / busy_cycles_o performance counters.
module bsg_activation_arbiter
    import bsg_activation_pkg::*;
#(
    parameter int num_req_p   = 4,
    parameter int ang_width_p = 21,
    parameter int precision_p = 16,
    parameter int id_width_p  = $clog2(num_req_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*ang_width_p-1:0] req_ang_i,
    input  logic [num_req_p-1:0]             req_tanh_sel_i,
    output logic [num_req_p-1:0]             req_ready_o,
    output logic [ang_width_p-1:0]           eng_ang_o,
    output logic                             eng_tanh_sel_o,
    output logic                             eng_v_o,
    input  logic                             eng_ready_i,
    input  logic [precision_p:0]             eng_data_i,
    input  logic                             eng_v_i,
    output logic                             eng_yumi_o,
    output logic                             v_o,
    output logic [precision_p:0]             data_o,
    output logic [id_width_p-1:0]            id_o,
    input  logic                             ready_i
`ifdef BSG_ACTIVATION_ARBITER_PERF_EN
    ,
    output logic [num_req_p*32-1:0]          grant_count_o,
    output logic [31:0]                      busy_cycles_o
`endif
);

    bsg_activation_arb_state_e state_q, state_d;
    logic [id_width_p-1:0]     last_q, last_d;
    logic [ang_width_p-1:0]    ang_q, ang_d;
    logic                      tanh_sel_q, tanh_sel_d;
    logic [id_width_p-1:0]     id_q, id_d;

    logic [num_req_p-1:0]      grant_s;
    logic [id_width_p-1:0]     winner_s;
    logic                      any_v_s;
    logic                      accept_s;

    bsg_activation_rr_pick #(
        .num_req_p  (num_req_p),
        .id_width_p (id_width_p)
    ) u_rr_pick (
        .v_i      (req_v_i),
        .last_i   (last_q),
        .grant_o  (grant_s),
        .winner_o (winner_s),
        .any_v_o  (any_v_s)
    );

    assign accept_s = (state_q == e_IDLE) & any_v_s;

    // State and transaction-capture registers; last_q starts at the top so requester 0 goes first.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_IDLE;
            last_q     <= id_width_p'(num_req_p - 1);
            ang_q      <= '0;
            tanh_sel_q <= 1'b0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            ang_q      <= ang_d;
            tanh_sel_q <= tanh_sel_d;
            id_q       <= id_d;
        end
    end

    // Next-state logic; angle and function select are captured only at grant time.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        ang_d      = ang_q;
        tanh_sel_d = tanh_sel_q;
        id_d       = id_q;
        case (state_q)
            e_IDLE: begin
                if (any_v_s) begin
                    state_d    = e_ISSUE;
                    last_d     = winner_s;
                    id_d       = winner_s;
                    ang_d      = req_ang_i[int'(winner_s)*ang_width_p +: ang_width_p];
                    tanh_sel_d = req_tanh_sel_i[winner_s];
                end else begin
                    state_d = e_IDLE;
                end
            end
            e_ISSUE: begin
                if (eng_ready_i) begin
                    state_d = e_BUSY;
                end else begin
                    state_d = e_ISSUE;
                end
            end
            e_BUSY: begin
                if (eng_v_i && ready_i) begin
                    state_d = e_IDLE;
                end else begin
                    state_d = e_BUSY;
                end
            end
            default: begin
                state_d = e_IDLE;
            end
        endcase
    end

    // Output decode; req_ready_o is masked during reset so nothing is accepted while it is held.
    always_comb begin
        req_ready_o    = '0;
        eng_v_o        = 1'b0;
        eng_yumi_o     = 1'b0;
        v_o            = 1'b0;
        data_o         = '0;
        eng_ang_o      = ang_q;
        eng_tanh_sel_o = tanh_sel_q;
        id_o           = id_q;
        case (state_q)
            e_IDLE: begin
                req_ready_o = reset_i ? '0 : grant_s;
            end
            e_ISSUE: begin
                eng_v_o = 1'b1;
            end
            e_BUSY: begin
                v_o        = eng_v_i;
                data_o     = eng_data_i;
                eng_yumi_o = ready_i & eng_v_i;
            end
            default: begin
                req_ready_o = '0;
            end
        endcase
    end

`ifdef BSG_ACTIVATION_ARBITER_PERF_EN
    logic [bsg_act_cnt_width_lp-1:0] grant_cnt_q [num_req_p];
    logic [bsg_act_cnt_width_lp-1:0] grant_cnt_d [num_req_p];
    logic [bsg_act_cnt_width_lp-1:0] busy_cnt_q, busy_cnt_d;

    // Saturating per-requester grant counts and non-idle cycle count.
    always_comb begin
        for (int k = 0; k < num_req_p; k++) begin
            grant_cnt_d[k] = (accept_s && (winner_s == id_width_p'(k)))
                           ? bsg_act_sat_inc(grant_cnt_q[k]) : grant_cnt_q[k];
        end
        busy_cnt_d = (state_q != e_IDLE) ? bsg_act_sat_inc(busy_cnt_q) : busy_cnt_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < num_req_p; k++) begin
                grant_cnt_q[k] <= '0;
            end
            busy_cnt_q <= '0;
        end else begin
            for (int k = 0; k < num_req_p; k++) begin
                grant_cnt_q[k] <= grant_cnt_d[k];
            end
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        for (int k = 0; k < num_req_p; k++) begin
            grant_count_o[k*32 +: 32] = grant_cnt_q[k];
        end
        busy_cycles_o = busy_cnt_q;
    end
`endif

endmodule

// File: tb/tb_bsg_activation_arbiter.sv
// Randomized self-checking bench for bsg_activation_arbiter with a fixed-latency engine stub.
module tb_bsg_activation_arbiter;
    localparam int N  = 4;
    localparam int AW = 21;
    localparam int P  = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N-1:0]    req_v_i;
    logic [N*AW-1:0] req_ang_i;
    logic [N-1:0]    req_tanh_sel_i;
    logic [N-1:0]    req_ready_o;
    logic [AW-1:0]   eng_ang_o;
    logic            eng_tanh_sel_o;
    logic            eng_v_o;
    logic            eng_ready_i;
    logic [P:0]      eng_data_i;
    logic            eng_v_i;
    logic            eng_yumi_o;
    logic            v_o;
    logic [P:0]      data_o;
    logic [IW-1:0]   id_o;
    logic            ready_i;
`ifdef BSG_ACTIVATION_ARBITER_PERF_EN
    logic [N*32-1:0] grant_count_o;
    logic [31:0]     busy_cycles_o;
`endif

    int checks = 0;
    int errors = 0;
    int last_m;
    int busy_m;
    int grants_m [N];
    logic [AW-1:0] ang_m [N];
    logic          sel_m [N];

    always #5 clk = ~clk;

    bsg_activation_arbiter dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .req_v_i        (req_v_i),
        .req_ang_i      (req_ang_i),
        .req_tanh_sel_i (req_tanh_sel_i),
        .req_ready_o    (req_ready_o),
        .eng_ang_o      (eng_ang_o),
        .eng_tanh_sel_o (eng_tanh_sel_o),
        .eng_v_o        (eng_v_o),
        .eng_ready_i    (eng_ready_i),
        .eng_data_i     (eng_data_i),
        .eng_v_i        (eng_v_i),
        .eng_yumi_o     (eng_yumi_o),
        .v_o            (v_o),
        .data_o         (data_o),
        .id_o           (id_o),
        .ready_i        (ready_i)
`ifdef BSG_ACTIVATION_ARBITER_PERF_EN
        ,
        .grant_count_o  (grant_count_o),
        .busy_cycles_o  (busy_cycles_o)
`endif
    );

    // Engine stub: accepts when idle, returns ang+1 (truncated) 5 cycles later, holds until taken.
    logic          stub_busy;
    int            stub_cnt;
    logic [AW-1:0] stub_ang;
    assign eng_ready_i = ~stub_busy;
    assign eng_v_i     = stub_busy && (stub_cnt == 0);
    assign eng_data_i  = stub_ang[P:0] + 17'd1;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
            stub_ang  <= '0;
        end else if (!stub_busy && eng_v_o) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 4;
            stub_ang  <= eng_ang_o;
        end else if (stub_busy && stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
        end else if (stub_busy && eng_yumi_o) begin
            stub_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_reqs();
        for (int k = 0; k < N; k++) begin
            req_ang_i[k*AW +: AW] = ang_m[k];
            req_tanh_sel_i[k]     = sel_m[k];
        end
    endtask

    task automatic randomize_reqs();
        for (int k = 0; k < N; k++) begin
            ang_m[k] = AW'($urandom);
            sel_m[k] = 1'($urandom);
        end
        set_reqs();
    endtask

    // Reference round robin: first valid index after 'last', wrapping modulo N.
    function automatic int rr_model(input int last, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; the calling cycle must be an idle cycle with inputs about to be set.
    task automatic do_txn(input logic [N-1:0] mask_grant, input logic [N-1:0] mask_busy,
                          input int stall, output int w_o);
        int            w;
        int            cyc;
        logic [AW-1:0] exp_ang;
        logic          exp_sel;
        logic [P:0]    exp_data;
        req_v_i = mask_grant;
        set_reqs();
        #1;
        w = rr_model(last_m, mask_grant);
        w_o = w;
        chk("grant_onehot", 64'(req_ready_o), 64'(1) << w);
        exp_ang  = ang_m[w];
        exp_sel  = sel_m[w];
        exp_data = exp_ang[P:0] + 17'd1;
        tick();
        last_m = w;
        grants_m[w]++;
        busy_m++;
        req_v_i = mask_busy;
        randomize_reqs();
        #1;
        chk("issue_valid", 64'(eng_v_o), 64'(1));
        chk("issue_ang", 64'(eng_ang_o), 64'(exp_ang));
        chk("issue_sel", 64'(eng_tanh_sel_o), 64'(exp_sel));
        cyc = 0;
        while (v_o !== 1'b1 && cyc < 40) begin
            chk("busy_no_grant", 64'(req_ready_o), 64'(0));
            chk("busy_ang_stable", 64'({eng_tanh_sel_o, eng_ang_o}), 64'({exp_sel, exp_ang}));
            tick();
            busy_m++;
            cyc++;
        end
        chk("result_valid", 64'(v_o), 64'(1));
        chk("result_data", 64'(data_o), 64'(exp_data));
        chk("result_id", 64'(id_o), 64'(w));
        for (int s = 0; s < stall; s++) begin
            ready_i = 1'b0;
            #1;
            chk("stall_valid", 64'(v_o), 64'(1));
            chk("stall_data", 64'(data_o), 64'(exp_data));
            chk("stall_id", 64'(id_o), 64'(w));
            chk("stall_yumi", 64'(eng_yumi_o), 64'(0));
            chk("stall_no_grant", 64'(req_ready_o), 64'(0));
            tick();
            busy_m++;
        end
        ready_i = 1'b1;
        #1;
        chk("handshake_yumi", 64'(eng_yumi_o), 64'(1));
        tick();
    endtask

    initial begin
        int w;
        int exp_order [6];
        exp_order = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < N; k++) begin
            grants_m[k] = 0;
            ang_m[k]    = '0;
            sel_m[k]    = 1'b0;
        end
        busy_m         = 0;
        last_m         = N - 1;
        reset_i        = 1'b1;
        ready_i        = 1'b1;
        req_v_i        = 4'hF;
        req_ang_i      = '0;
        req_tanh_sel_i = '0;
        randomize_reqs();
        #1;
        chk("rst_req_ready", 64'(req_ready_o), 64'(0));
        chk("rst_eng_v", 64'(eng_v_o), 64'(0));
        chk("rst_eng_ang", 64'({eng_tanh_sel_o, eng_ang_o}), 64'(0));
        chk("rst_outputs", 64'({v_o, data_o, id_o, eng_yumi_o}), 64'(0));
        tick();
        tick();
        reset_i = 1'b0;

        // All four held valid from reset: strict rotation.
        for (int i = 0; i < 6; i++) begin
            randomize_reqs();
            do_txn(4'hF, 4'hF, 0, w);
            chk("rotation_order", 64'(w), 64'(exp_order[i]));
        end

        // Single requester with known operands.
        ang_m[0] = 21'h08000;
        sel_m[0] = 1'b1;
        do_txn(4'b0001, 4'b0001, 0, w);
        chk("single_req_id", 64'(w), 64'(0));

        // Long downstream stall.
        randomize_reqs();
        do_txn(4'b0110, 4'b0110, 10, w);

        // Requester raised while busy is picked ahead of an idle lower index.
        randomize_reqs();
        do_txn(4'b0001, 4'b0101, 0, w);
        do_txn(4'b0101, 4'b0000, 0, w);
        chk("skip_idle_req", 64'(w), 64'(2));

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            randomize_reqs();
            do_txn(N'($urandom_range(1, 15)), N'($urandom_range(0, 15)),
                   $urandom_range(0, 3), w);
        end

        // Reset asserted while the engine is working.
        req_v_i = 4'b0100;
        #1;
        tick();
        tick();
        tick();
        req_v_i = 4'hF;
        reset_i = 1'b1;
        #1;
        chk("midrst_req_ready", 64'(req_ready_o), 64'(0));
        chk("midrst_eng", 64'({eng_v_o, eng_tanh_sel_o, eng_ang_o}), 64'(0));
        chk("midrst_outputs", 64'({v_o, data_o, id_o, eng_yumi_o}), 64'(0));
        tick();
        tick();
        reset_i = 1'b0;
        last_m  = N - 1;
        busy_m  = 0;
        for (int k = 0; k < N; k++) grants_m[k] = 0;
        randomize_reqs();
        do_txn(4'hF, 4'b0010, 0, w);
        chk("post_rst_priority", 64'(w), 64'(0));
        for (int i = 0; i < 3; i++) begin
            randomize_reqs();
            do_txn(4'b0010, 4'b0010, i, w);
        end
        req_v_i = 4'b0000;
        #1;
`ifdef BSG_ACTIVATION_ARBITER_PERF_EN
        for (int k = 0; k < N; k++) begin
            chk("perf_grant_count", 64'(grant_count_o[k*32 +: 32]), 64'(grants_m[k]));
        end
        chk("perf_busy_cycles", 64'(busy_cycles_o), 64'(busy_m));
`endif
        chk("final_idle", 64'({v_o, eng_v_o, req_ready_o}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_activation_arbiter.md
# bsg_activation_arbiter

Round-robin arbiter and sequencer that shares one `bsg_activation` engine (tanh/sigmoid) among `num_req_p` requesters. It grants one requester at a time and registers that requester's angle and function select. It holds those values stable to the engine for the whole transaction, then returns the engine result tagged with the requester id. It sits between requester pipelines and a single engine instance.

## Interface
- `num_req_p`, default 4: number of requesters (≥2).
- `ang_width_p`, default 21: angle width; must match the engine.
- `precision_p`, default 16: engine fraction bits; result width is `precision_p+1`.
- `id_width_p`, default `$clog2(num_req_p)`: tag width.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; asynchronous, active-high.
- `req_v_i`  in  `num_req_p`  per-requester valid.
- `req_ang_i`  in  `num_req_p*ang_width_p`  packed signed angles; requester k occupies slice k.
- `req_tanh_sel_i`  in  `num_req_p`  1 = tanh, 0 = sigmoid.
- `req_ready_o`  out  `num_req_p`  one-hot-or-zero accept.
- `eng_ang_o`  out  `ang_width_p`  to engine `ang_i`.
- `eng_tanh_sel_o`  out  1  to engine `tanh_sel_i`.
- `eng_v_o`  out  1  to engine `val_i`.
- `eng_ready_i`  in  1  from engine `ready_o`.
- `eng_data_i`  in  `precision_p+1`  from engine `data_o`.
- `eng_v_i`  in  1  from engine `val_o`.
- `eng_yumi_o`  out  1  to engine `ready_i`.
- `v_o`  out  1  result valid.
- `data_o`  out  `precision_p+1`  result.
- `id_o`  out  `id_width_p`  requester tag.
- `ready_i`  in  1  downstream accept.

## Operation
- States: `e_IDLE`, `e_ISSUE`, `e_BUSY`.
- `e_IDLE`: the round-robin pick selects the first valid requester, searching from `last_r+1` modulo `num_req_p`.
  - If any requester is valid: `req_ready_o[winner]`=1, capture `ang_r`, `tanh_sel_r`, `id_r`, set `last_r<=winner`, go to `e_ISSUE`.
  - If no requester is valid: stay in `e_IDLE`.
- `e_ISSUE`: `eng_v_o`=1. When `eng_ready_i` is high, go to `e_BUSY`.
- `e_BUSY`:
  - `v_o`=`eng_v_i`, `data_o`=`eng_data_i`, `eng_yumi_o`=`ready_i & eng_v_i`.
  - When `eng_v_i & ready_i`, go to `e_IDLE`.
- `eng_ang_o`=`ang_r` and `eng_tanh_sel_o`=`tanh_sel_r` in every state. The engine reads `tanh_sel_i` and the angle sign throughout the transaction, so these must never change mid-transaction.
- `id_o`=`id_r`. It is valid whenever `v_o`=1.
- `req_ready_o` is all zero outside `e_IDLE`. `req_ready_o` depends combinationally on `req_v_i`; requesters must not make `req_v_i` depend on `req_ready_o`.
- The engine's reset is not driven here. The engine must be reset by the same reset source, synchronized to its synchronous reset.

## Timing
- Reset values:
  - State `e_IDLE`; `last_r`=`num_req_p-1`, so requester 0 has first priority.
  - `ang_r`, `tanh_sel_r`, `id_r` = 0.
  - Outputs `req_ready_o`=0, `eng_v_o`=0, `eng_yumi_o`=0, `v_o`=0, `data_o`=0, `id_o`=0.
- Accept in cycle t → `eng_v_o` high at t+1. If the engine is ready, it is in `e_BUSY` at t+2.
- Overall latency = 2 + engine latency. After a result handshake at t, a new grant can occur at t+1.
- `ready_i` low with `v_o` high: hold in `e_BUSY`; `data_o`/`id_o` stable; no grants.
- A requester valid during a busy period is considered at the next `e_IDLE`. Only one grant is made per `e_IDLE` visit.
- Reset asserted mid-transaction: state, registers and outputs go to reset values immediately (asynchronous). The in-flight result is discarded.

## Configuration
- `BSG_ACTIVATION_ARBITER_PERF_EN` defined:
  - Adds output `grant_count_o` [`num_req_p*32`]: per-requester saturating grant counters.
  - Adds output `busy_cycles_o` [32]: saturating count of cycles not in `e_IDLE`.
  - Both are cleared by reset.
- Undefined: these ports and counters are absent. Behavior is otherwise identical.

## Structure
- A shared package `bsg_activation_pkg` holds:
  - the state enum `bsg_activation_arb_state_e`;
  - the fixed-point constant ONE (`1 << precision_p`);
  - the counter width constant (32).
- One sub-module, `bsg_activation_rr_pick`. It is combinational: inputs are the valid vector and `last_r`; outputs are the one-hot grant, the encoded winner and any-valid.

## Test plan
Engine stub returns `ang+1` (truncated) 5 cycles after accept. Unless stated otherwise, `ready_i`=1.
1. Only req0 valid, `ang`=0x08000, tanh=1 → `eng_ang_o`=0x08000, `eng_tanh_sel_o`=1 stable until the handshake; `data_o`=0x08001, `id_o`=0.
2. All 4 requesters held valid from reset → grant order 0,1,2,3,0,1; exactly one `req_ready_o` bit per grant.
3. `ready_i` low for 10 cycles while `v_o`=1 → `data_o`/`id_o` constant, `eng_yumi_o`=0, `req_ready_o`=0; release → handshake, grant on the next cycle.
4. req0 granted, req2 raised while busy, req1 idle → next grant is req2; req1 is skipped.
5. Reset asserted in `e_BUSY` → all outputs 0 in the same cycle; after release, req0 has first priority.
6. With `BSG_ACTIVATION_ARBITER_PERF_EN`: 3 transactions on req1 → `grant_count_o` slice 1 = 3, other slices 0; `busy_cycles_o` equals the observed count of cycles not in `e_IDLE`.
